// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with terminal-count pulse.
// One-shot or periodic (auto-reload) operation, selected when the timer is started.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | not counting; counter is 0; a start loads and arms the timer
//   RUN   | counting down on enabled cycles; expires when counter is 1
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] reload_value,
  input  logic             periodic,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] counter,
  output logic             busy,
  output logic             expired
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] counter_nxt;
  logic [WIDTH-1:0] reload_q, reload_nxt;
  logic             mode_q, mode_nxt;
  logic             expired_nxt;

  // State, count, latched settings and outputs; everything clears on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      counter  <= CNT_ZERO;
      reload_q <= CNT_ZERO;
      mode_q   <= 1'b0;
      busy     <= 1'b0;
      expired  <= 1'b0;
    end else begin
      state    <= state_nxt;
      counter  <= counter_nxt;
      reload_q <= reload_nxt;
      mode_q   <= mode_nxt;
      busy     <= (state_nxt == RUN);
      expired  <= expired_nxt;
    end
  end

  // Next-state decode: abort beats start, start beats a decrement or expiry.
  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    reload_nxt  = reload_q;
    mode_nxt    = mode_q;
    expired_nxt = 1'b0;

    if (abort) begin
      // abort in IDLE leaves it idle; in RUN it drops back without a pulse
      state_nxt   = IDLE;
      counter_nxt = CNT_ZERO;
    end else if (start) begin
      reload_nxt = reload_value;
      mode_nxt   = periodic;
      if (reload_value == CNT_ZERO) begin
        // zero-length timer expires at once and never enters RUN
        state_nxt   = IDLE;
        counter_nxt = CNT_ZERO;
        expired_nxt = 1'b1;
      end else begin
        state_nxt   = RUN;
        counter_nxt = reload_value;
      end
    end else if (state == RUN && enable) begin
      if (counter == CNT_ONE) begin
        expired_nxt = 1'b1;
        if (mode_q) begin
          counter_nxt = reload_q;
        end else begin
          counter_nxt = CNT_ZERO;
          state_nxt   = IDLE;
        end
      end else begin
        counter_nxt = counter - CNT_ONE;
      end
    end
  end

endmodule
